// File: rtl/wb_queue_pkg.sv
// Shared widths and entry type for the writeback queue and the register file.
package wb_queue_pkg;

    localparam int REG_W    = 4;   // register id width
    localparam int DATA_W   = 16;  // register data width
    localparam int WB_DEPTH = 4;   // default number of pending writebacks

    typedef logic [REG_W-1:0]  regId_t;
    typedef logic [DATA_W-1:0] regData_t;

    typedef struct packed {
        regId_t   regId;
        regData_t data;
    } wbEntry_t;

endpackage

// File: rtl/wb_queue_if.sv
// Bus bundle between the producer, the register file and the writeback queue.
interface wb_queue_if import wb_queue_pkg::*; #(
    parameter int DEPTH = WB_DEPTH
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    // producer side
    logic           in_valid;
    logic           in_ready;
    regId_t         in_reg;
    regData_t       in_data;

    // register-file write port
    logic           drain_en;
    logic           WriteReg;
    regId_t         DstReg;
    regData_t       DstData;

    // forwarding lookups
    regId_t         SrcReg1;
    regId_t         SrcReg2;
    logic           Fwd1Hit;
    logic           Fwd2Hit;
    regData_t       Fwd1Data;
    regData_t       Fwd2Data;

    // occupancy
    logic [CW-1:0]  count;
    logic           empty;
    logic           full;

    modport slave (
        input  in_valid, in_reg, in_data, drain_en, SrcReg1, SrcReg2,
        output in_ready, WriteReg, DstReg, DstData,
               Fwd1Hit, Fwd2Hit, Fwd1Data, Fwd2Data, count, empty, full
    );

    modport master (
        output in_valid, in_reg, in_data, drain_en, SrcReg1, SrcReg2,
        input  in_ready, WriteReg, DstReg, DstData,
               Fwd1Hit, Fwd2Hit, Fwd1Data, Fwd2Data, count, empty, full
    );

endinterface

// File: rtl/wb_queue_match.sv
// Forwarding lookup: finds the newest valid queue entry whose register id
// matches lookupId. Entries are scanned oldest-to-newest starting at headPtr,
// so a later match overwrites an earlier one.
module wb_match import wb_queue_pkg::*; #(
    parameter  int DEPTH = WB_DEPTH,
    localparam int PW    = $clog2(DEPTH)
) (
    input  wbEntry_t [DEPTH-1:0] entries,
    input  logic     [DEPTH-1:0] entryVld,
    input  logic     [PW-1:0]    headPtr,
    input  regId_t               lookupId,
    output logic                 hit,
    output regData_t             hitData
);

    // age-ordered scan; the newest hit wins, data is zero on a miss
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        hit     = 1'b0;
        hitData = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = headPtr + PW'(k);
            if (entryVld[idx] && (entries[idx].regId == lookupId)) begin
                hit     = 1'b1;
                hitData = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: buffers results in arrival order ahead of the register
// file write port and forwards pending data to two readers.
module wb_queue import wb_queue_pkg::*; #(
    parameter  int DEPTH = WB_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    wb_queue_if.slave    bus
);

    wbEntry_t [DEPTH-1:0] entries;
    logic     [DEPTH-1:0] entryVld;
    logic     [PW-1:0]    headPtr;
    logic     [PW-1:0]    tailPtr;
    logic     [CW-1:0]    cnt;

    logic enq;
    logic deq;
    logic isEmpty;
    logic isFull;

    assign isEmpty = (cnt == '0);
    assign isFull  = (cnt == CW'(DEPTH));

    // a dequeue in the same cycle does not open a slot for the producer
    assign enq = bus.in_valid && !isFull;
    assign deq = bus.drain_en && !isEmpty;

    // pointers, valid flags and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            cnt      <= '0;
            entryVld <= '0;
        end else begin
            if (enq) begin
                entryVld[tailPtr] <= 1'b1;
                tailPtr           <= tailPtr + PW'(1);
            end
            if (deq) begin
                entryVld[headPtr] <= 1'b0;
                headPtr           <= headPtr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // entry payload; qualified by entryVld so it needs no reset
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            entries[tailPtr] <= '{regId: bus.in_reg, data: bus.in_data};
        end
    end

    // register-file write port presents the head entry, zeros when empty
    assign bus.WriteReg = deq;
    assign bus.DstReg   = isEmpty ? '0 : entries[headPtr].regId;
    assign bus.DstData  = isEmpty ? '0 : entries[headPtr].data;

    assign bus.in_ready = !isFull;
    assign bus.count    = cnt;
    assign bus.empty    = isEmpty;
    assign bus.full     = isFull;

    // two identical forwarding lookups
    regId_t   [1:0] srcId;
    logic     [1:0] fwdHit;
    regData_t [1:0] fwdData;

    assign srcId[0] = bus.SrcReg1;
    assign srcId[1] = bus.SrcReg2;

    for (genvar g = 0; g < 2; g++) begin : gLookup
        wb_match #(.DEPTH(DEPTH)) uMatch (
            .entries  (entries),
            .entryVld (entryVld),
            .headPtr  (headPtr),
            .lookupId (srcId[g]),
            .hit      (fwdHit[g]),
            .hitData  (fwdData[g])
        );
    end

    assign bus.Fwd1Hit  = fwdHit[0];
    assign bus.Fwd1Data = fwdData[0];
    assign bus.Fwd2Hit  = fwdHit[1];
    assign bus.Fwd2Data = fwdData[1];

endmodule
